hs2way_sink_fifo: RTL and testbench

Synthesizable slave endpoint of the hs2way push/wait_n handshake. It accepts words pushed by an hs2way master into a parametric circular FIFO and presents them to local logic through a show-ahead pop port. It sits at the receive end of any hs2way link, as the RTL counterpart of the bench slave driver. It provides registered back-pressure and a sticky pop-underflow flag.

---
 rtl/hs2way_sink_fifo.sv | 94 +++++++++
 tb/tb_hs2way_sink_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hs2way_sink_fifo.sv
// hs2way_sink_fifo: slave endpoint of the hs2way push/wait_n handshake.
// Accepted words land in a circular FIFO and are presented show-ahead on
// the pop port. Back-pressure is registered, and a sticky flag records any
// pop attempted while the FIFO is empty.
module hs2way_sink_fifo #(
  parameter int g_data_size = 8,
  parameter int g_depth     = 8
) (
  input  logic                         p_clock,
  input  logic                         p_reset,
  input  logic                         p_push,
  output logic                         p_wait_n,
  input  logic [g_data_size-1:0]       p_data,
  input  logic                         p_pop,
  output logic                         p_valid,
  output logic [g_data_size-1:0]       p_rd_data,
  output logic [$clog2(g_depth):0]     p_level,
  output logic                         p_underflow
);

  localparam int PW = $clog2(g_depth);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(g_depth);

  logic [g_data_size-1:0] mem [g_depth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wait_n_q, wait_n_d;
  logic          underflow_q, underflow_d;

  logic accept;
  logic pop_ok;
  logic not_empty;

  assign not_empty = (level_q != '0);
  // The registered wait_n already guarantees a free slot, so no level test here.
  assign accept    = p_push & wait_n_q;
  assign pop_ok    = p_pop & not_empty;

  // Next-state computation for pointers, occupancy, back-pressure and flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;

    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({accept, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (p_pop && !not_empty) underflow_d = 1'b1;

    wait_n_d = (level_d < DEPTH_L);
  end

  // Control state: synchronous reset discards everything, including this cycle's traffic.
  always_ff @(posedge p_clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (p_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wait_n_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wait_n_q    <= wait_n_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; a word is stored only on an accepted push outside reset.
  always_ff @(posedge p_clock) begin
    // NOTE: storage is deliberately not reset; the level and pointers define what is valid.
    if (!p_reset && accept) mem[wr_ptr_q] <= p_data;
  end

  assign p_wait_n    = wait_n_q;
  assign p_valid     = not_empty;
  assign p_rd_data   = mem[rd_ptr_q];
  assign p_level     = level_q;
  assign p_underflow = underflow_q;

endmodule

// File: tb/tb_hs2way_sink_fifo.sv
// Self-checking bench for hs2way_sink_fifo: a vector table for fill/drain,
// hand sequences for the multi-cycle corner cases, then randomized traffic
// against a queue-based reference model.
module tb_hs2way_sink_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] data;
  logic          wait_n;
  logic          valid;
  logic [DW-1:0] rd;
  logic [LW-1:0] level;
  logic          uf;

  hs2way_sink_fifo #(.g_data_size(DW), .g_depth(DEPTH)) dut (
    .p_clock     (clk),
    .p_reset     (rst),
    .p_push      (push),
    .p_wait_n    (wait_n),
    .p_data      (data),
    .p_pop       (pop),
    .p_valid     (valid),
    .p_rd_data   (rd),
    .p_level     (level),
    .p_underflow (uf)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a queue of stored words plus the two flag bits.
  logic [DW-1:0] mq [$];
  bit            m_wait = 1'b0;
  bit            m_uf   = 1'b0;

  typedef struct {
    bit            push;
    logic [DW-1:0] data;
    bit            pop;
    bit            rst;
    bit            e_wait;
    bit            e_valid;
    int            e_level;
    bit            e_uf;
    bit            chk_rd;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tv [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic apply(input bit p, input logic [DW-1:0] d, input bit o, input bit r);
    bit acc;
    bit take;
    push = p; data = d; pop = o; rst = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_uf   = 1'b0;
      m_wait = 1'b0;
    end else begin
      acc  = p && m_wait;
      take = o && (mq.size() != 0);
      if (o && mq.size() == 0) m_uf = 1'b1;
      if (take) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      m_wait = (mq.size() < DEPTH);
    end
    #1;
  endtask

  task automatic check_model(input string name);
    check({name, ".wait_n"},    32'(wait_n), 32'(m_wait));
    check({name, ".valid"},     32'(valid),  32'(mq.size() != 0));
    check({name, ".level"},     32'(level),  32'(mq.size()));
    check({name, ".underflow"}, 32'(uf),     32'(m_uf));
    if (mq.size() != 0) check({name, ".rd_data"}, 32'(rd), 32'(mq[0]));
  endtask

  function automatic vec_t mk(bit p, logic [DW-1:0] d, bit o, bit r, bit ew, bit ev,
                              int el, bit eu, bit cr, logic [DW-1:0] er);
    vec_t v;
    v.push = p; v.data = d; v.pop = o; v.rst = r;
    v.e_wait = ew; v.e_valid = ev; v.e_level = el; v.e_uf = eu;
    v.chk_rd = cr; v.e_rd = er;
    return v;
  endfunction

  logic [DW-1:0] seq [$];

  initial begin
    push = 1'b0; pop = 1'b0; data = '0; rst = 1'b1;

    // ---------------- table: reset/idle, fill, held 9th push, drain
    for (int i = 0; i < 3; i++) tv.push_back(mk(1, 8'hEE, 0, 1, 0, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));
    for (int k = 1; k <= 8; k++)
      tv.push_back(mk(1, DW'(k), 0, 0, (k < 8), 1, k, 0, 1, 8'h01));
    for (int k = 0; k < 4; k++) tv.push_back(mk(1, 8'h09, 0, 0, 0, 1, 8, 0, 1, 8'h01));
    for (int i = 1; i <= 8; i++)
      tv.push_back(mk(0, 8'h00, 1, 0, 1, (i < 8), 8 - i, 0, (i < 8), DW'(i + 1)));

    foreach (tv[i]) begin
      apply(tv[i].push, tv[i].data, tv[i].pop, tv[i].rst);
      check($sformatf("tbl%0d.wait_n", i), 32'(wait_n), 32'(tv[i].e_wait));
      check($sformatf("tbl%0d.valid", i),  32'(valid),  32'(tv[i].e_valid));
      check($sformatf("tbl%0d.level", i),  32'(level),  32'(tv[i].e_level));
      check($sformatf("tbl%0d.uf", i),     32'(uf),     32'(tv[i].e_uf));
      if (tv[i].chk_rd) check($sformatf("tbl%0d.rd", i), 32'(rd), 32'(tv[i].e_rd));
    end

    // ---------------- full with simultaneous push/pop
    for (int k = 0; k < 8; k++) apply(1, DW'(8'h30 + k), 0, 0);
    check("full.level", 32'(level), 32'd8);
    check("full.wait_n", 32'(wait_n), 32'd0);
    apply(1, 8'hAA, 1, 0);
    check("fullpp.level", 32'(level), 32'd7);
    check("fullpp.rd", 32'(rd), 32'h31);
    check("fullpp.wait_n", 32'(wait_n), 32'd1);
    apply(1, 8'hAA, 0, 0);
    check("fullpp2.level", 32'(level), 32'd8);
    for (int k = 1; k < 8; k++) begin
      check($sformatf("fulldrain%0d.rd", k), 32'(rd), 32'(8'h30 + k));
      apply(0, 8'h00, 1, 0);
    end
    check("fulldrain.last", 32'(rd), 32'hAA);
    apply(0, 8'h00, 1, 0);
    check("fulldrain.empty", 32'(valid), 32'd0);

    // ---------------- wrap-around with 3 pre-loaded words
    apply(0, 8'h00, 0, 1);
    apply(0, 8'h00, 0, 0);
    seq = {8'hA0, 8'hA1, 8'hA2};
    foreach (seq[i]) apply(1, seq[i], 0, 0);
    for (int i = 0; i < 20; i++) seq.push_back(DW'(8'h10 + i));
    for (int i = 0; i < 20; i++) begin
      apply(1, DW'(8'h10 + i), 1, 0);
      check($sformatf("wrap%0d.level", i), 32'(level), 32'd3);
      check($sformatf("wrap%0d.rd", i), 32'(rd), 32'(seq[i + 1]));
    end

    // ---------------- underflow is sticky until reset
    apply(0, 8'h00, 0, 1);
    apply(0, 8'h00, 0, 0);
    check("uf.clear", 32'(uf), 32'd0);
    apply(0, 8'h00, 1, 0);
    check("uf.set", 32'(uf), 32'd1);
    check("uf.level", 32'(level), 32'd0);
    apply(1, 8'h41, 1, 0);   // empty: push taken, pop ignored
    check("uf.pushpop.level", 32'(level), 32'd1);
    check("uf.pushpop.rd", 32'(rd), 32'h41);
    for (int k = 0; k < 4; k++) apply(1, DW'(8'h42 + k), 0, 0);
    apply(0, 8'h00, 1, 0);
    check("uf.sticky", 32'(uf), 32'd1);
    check("uf.rd", 32'(rd), 32'h42);

    // ---------------- reset mid-operation at level 5
    check("midrst.pre.level", 32'(level), 32'd4);
    apply(1, 8'h46, 0, 0);
    check("midrst.pre5", 32'(level), 32'd5);
    apply(1, 8'h99, 1, 1);
    check("midrst.level", 32'(level), 32'd0);
    check("midrst.valid", 32'(valid), 32'd0);
    check("midrst.uf", 32'(uf), 32'd0);
    check("midrst.wait_n", 32'(wait_n), 32'd0);
    apply(0, 8'h00, 0, 0);
    check("midrst.wait_up", 32'(wait_n), 32'd1);
    apply(1, 8'h55, 0, 0);
    apply(1, 8'h66, 0, 0);
    check("midrst.rd0", 32'(rd), 32'h55);
    apply(0, 8'h00, 1, 0);
    check("midrst.rd1", 32'(rd), 32'h66);
    apply(0, 8'h00, 1, 0);
    check("midrst.empty", 32'(valid), 32'd0);
    check_model("post_hand");

    // ---------------- randomized traffic against the reference model
    apply(0, 8'h00, 0, 1);
    for (int i = 0; i < 600; i++) begin
      int pp;
      int op;
      pp = (i % 200 < 100) ? 80 : 30;   // alternate fill-heavy and drain-heavy phases
      op = (i % 200 < 100) ? 30 : 80;
      apply($urandom_range(0, 99) < pp, DW'($urandom),
            $urandom_range(0, 99) < op, $urandom_range(0, 149) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
